// File: rtl/branch_resolve_trainer.sv
// Execute-side companion of the perceptron predictor: tracks in-flight predictions, redirects on
// mispredict, repairs the speculative GHR and returns training updates over a valid/ready port.
module branch_resolve_trainer #(
   parameter int DEPTH    = 4,
   parameter int HIST_LEN = 16,
   parameter int SUM_W    = 10,
   parameter int THETA    = 30,
   localparam int TW      = $clog2(DEPTH)
) (
   input  logic                CLK,
   input  logic                RES,
   input  logic                HLT,
   input  logic                alloc_valid,
   output logic                alloc_ready,
   input  logic [31:0]         alloc_pc,
   input  logic                alloc_pred_taken,
   input  logic [SUM_W-1:0]    alloc_sum,
   output logic [TW-1:0]       alloc_tag,
   input  logic                res_valid,
   output logic                res_ready,
   input  logic [TW-1:0]       res_tag,
   input  logic                res_taken,
   input  logic [31:0]         res_target,
   output logic                flush,
   output logic [31:0]         flush_pc,
   output logic [HIST_LEN-1:0] ghr,
   output logic                train_valid,
   input  logic                train_ready,
   output logic [31:0]         train_pc,
   output logic                train_taken,
   output logic [HIST_LEN-1:0] train_hist,
   output logic [TW:0]         inflight,
   output logic                tag_err
);

   typedef enum logic [1:0] {
      E_FREE = 2'd0,
      E_PEND = 2'd1,
      E_DONE = 2'd2
   } entry_state_e;

   localparam int SW1 = SUM_W + 1;
   localparam int CW  = TW + 1;
   localparam logic [SUM_W:0] THETA_C = SW1'(THETA);
   localparam logic [TW:0]    DEPTH_C = CW'(DEPTH);

   entry_state_e        st_q    [DEPTH];
   entry_state_e        st_d    [DEPTH];
   logic [31:0]         pc_q    [DEPTH];
   logic                pred_q  [DEPTH];
   logic                taken_q [DEPTH];
   logic                misp_q  [DEPTH];
   logic                lowc_q  [DEPTH];
   logic [HIST_LEN-1:0] hist_q  [DEPTH];

   logic [TW-1:0]       wr_q, wr_d, rs_q, rs_d, rt_q, rt_d;
   logic [TW:0]         cnt_q, cnt_d;
   logic [HIST_LEN-1:0] ghr_q, ghr_d;
   logic                flush_q, flush_d;
   logic [31:0]         flush_pc_q, flush_pc_d;
   logic                tag_err_q, tag_err_d;

   logic [SUM_W:0]      sum_ext, sum_abs;
   logic                alloc_low_conf, alloc_fire, res_fire, mispredict_now;
   logic                rt_done, rt_needs_train, retire;
   logic [TW-1:0]       rs_off;

   // |sum| is taken one bit wider so the most negative sum does not wrap back to itself.
   assign sum_ext        = {alloc_sum[SUM_W-1], alloc_sum};
   assign sum_abs        = sum_ext[SUM_W] ? (~sum_ext + SW1'(1)) : sum_ext;
   assign alloc_low_conf = (sum_abs <= THETA_C);

   assign res_ready      = !HLT && (st_q[rs_q] == E_PEND);
   assign res_fire       = res_valid && res_ready;
   assign mispredict_now = res_fire && (res_taken != pred_q[rs_q]);
   assign alloc_ready    = !HLT && (cnt_q < DEPTH_C) && !mispredict_now;
   assign alloc_fire     = alloc_valid && alloc_ready;

   assign rt_done        = (st_q[rt_q] == E_DONE);
   assign rt_needs_train = misp_q[rt_q] || lowc_q[rt_q];
   assign retire         = !HLT && rt_done && (!rt_needs_train || train_ready);
   assign rs_off         = rs_q - rt_q;

   always_comb begin
      // NOTE: combinational next-state uses blocking '=' with every target defaulted first, so no latch is inferred.
      st_d       = st_q;
      wr_d       = wr_q;
      rs_d       = rs_q;
      rt_d       = rt_q;
      cnt_d      = cnt_q;
      ghr_d      = ghr_q;
      flush_d    = flush_q;
      flush_pc_d = flush_pc_q;
      tag_err_d  = tag_err_q;
      if (!HLT) begin
         flush_d    = 1'b0;
         flush_pc_d = '0;
         if (alloc_fire) begin
            st_d[wr_q] = E_PEND;
            wr_d       = wr_q + TW'(1);
            ghr_d      = {ghr_q[HIST_LEN-2:0], alloc_pred_taken};
         end
         if (retire) begin
            st_d[rt_q] = E_FREE;
            rt_d       = rt_q + TW'(1);
         end
         if (res_fire) begin
            st_d[rs_q] = E_DONE;
            rs_d       = rs_q + TW'(1);
            if (res_tag != rs_q) tag_err_d = 1'b1;
         end
         if (mispredict_now) begin
            // Everything allocated after rs is on the wrong path; rt..rs stay intact.
            for (int i = 0; i < DEPTH; i++) begin
               if (TW'(TW'(i) - rt_q) > rs_off) st_d[i] = E_FREE;
            end
            wr_d       = rs_q + TW'(1);
            ghr_d      = {hist_q[rs_q][HIST_LEN-2:0], res_taken};
            flush_d    = 1'b1;
            flush_pc_d = res_taken ? res_target : (pc_q[rs_q] + 32'd4);
            cnt_d      = CW'(rs_off) + CW'(1) - CW'(retire);
         end else begin
            cnt_d      = cnt_q + CW'(alloc_fire) - CW'(retire);
         end
      end
   end

   always_ff @(posedge CLK or negedge RES) begin
      if (!RES) begin
         for (int i = 0; i < DEPTH; i++) st_q[i] <= E_FREE;
         wr_q       <= '0;
         rs_q       <= '0;
         rt_q       <= '0;
         cnt_q      <= '0;
         ghr_q      <= '0;
         flush_q    <= 1'b0;
         flush_pc_q <= '0;
         tag_err_q  <= 1'b0;
      end else begin
         st_q       <= st_d;
         wr_q       <= wr_d;
         rs_q       <= rs_d;
         rt_q       <= rt_d;
         cnt_q      <= cnt_d;
         ghr_q      <= ghr_d;
         flush_q    <= flush_d;
         flush_pc_q <= flush_pc_d;
         tag_err_q  <= tag_err_d;
      end
   end

   // NOTE: entry payload is not reset; it is only ever read while the entry's state says it is valid.
   always_ff @(posedge CLK) begin
      if (alloc_fire) begin
         pc_q[wr_q]   <= alloc_pc;
         pred_q[wr_q] <= alloc_pred_taken;
         lowc_q[wr_q] <= alloc_low_conf;
         hist_q[wr_q] <= ghr_q;
      end
      if (res_fire) begin
         taken_q[rs_q] <= res_taken;
         misp_q[rs_q]  <= mispredict_now;
      end
   end

   assign alloc_tag   = wr_q;
   assign flush       = flush_q;
   assign flush_pc    = flush_pc_q;
   assign ghr         = ghr_q;
   assign inflight    = cnt_q;
   assign tag_err     = tag_err_q;
   assign train_valid = rt_done && rt_needs_train;
   assign train_pc    = train_valid ? pc_q[rt_q] : '0;
   assign train_taken = train_valid ? taken_q[rt_q] : 1'b0;
   assign train_hist  = train_valid ? hist_q[rt_q] : '0;

endmodule

// File: tb/tb_branch_resolve_trainer.sv
// Directed bench for branch_resolve_trainer (DEPTH=4, HIST_LEN=16, SUM_W=10, THETA=30).
module tb_branch_resolve_trainer;

   logic        CLK, RES, HLT;
   logic        alloc_valid, alloc_ready, alloc_pred_taken;
   logic [31:0] alloc_pc;
   logic [9:0]  alloc_sum;
   logic [1:0]  alloc_tag, res_tag;
   logic        res_valid, res_ready, res_taken;
   logic [31:0] res_target;
   logic        flush;
   logic [31:0] flush_pc;
   logic [15:0] ghr, train_hist;
   logic        train_valid, train_ready, train_taken;
   logic [31:0] train_pc;
   logic [2:0]  inflight;
   logic        tag_err;

   int tests = 0;
   int fails = 0;

   branch_resolve_trainer #(.DEPTH(4), .HIST_LEN(16), .SUM_W(10), .THETA(30)) dut (
      .CLK(CLK), .RES(RES), .HLT(HLT),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_pc(alloc_pc),
      .alloc_pred_taken(alloc_pred_taken), .alloc_sum(alloc_sum), .alloc_tag(alloc_tag),
      .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag),
      .res_taken(res_taken), .res_target(res_target),
      .flush(flush), .flush_pc(flush_pc), .ghr(ghr),
      .train_valid(train_valid), .train_ready(train_ready), .train_pc(train_pc),
      .train_taken(train_taken), .train_hist(train_hist),
      .inflight(inflight), .tag_err(tag_err)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic alloc(input logic [31:0] pc, input logic pred, input logic [9:0] sum);
      alloc_valid      = 1'b1;
      alloc_pc         = pc;
      alloc_pred_taken = pred;
      alloc_sum        = sum;
   endtask

   task automatic resolve(input logic [1:0] tag, input logic taken, input logic [31:0] tgt);
      res_valid  = 1'b1;
      res_tag    = tag;
      res_taken  = taken;
      res_target = tgt;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] t5_pc [4];
      logic [9:0]  t5_sum [4];
      RES = 1'b0; HLT = 1'b0;
      alloc_valid = 1'b0; alloc_pc = '0; alloc_pred_taken = 1'b0; alloc_sum = '0;
      res_valid = 1'b0; res_tag = '0; res_taken = 1'b0; res_target = '0;
      train_ready = 1'b0;
      #12;
      check("rst_inflight", inflight, 0);
      check("rst_flush", flush, 0);
      check("rst_train_valid", train_valid, 0);
      check("rst_ghr", ghr, 0);
      check("rst_tag_err", tag_err, 0);
      RES = 1'b1;
      step();

      // Test 1: four confident taken allocations fill the queue.
      for (int i = 0; i < 4; i++) begin
         alloc(32'h100 + 32'(4 * i), 1'b1, 10'd100);
         #1;
         check("t1_alloc_ready", alloc_ready, 1);
         check("t1_alloc_tag", alloc_tag, 32'(i));
         step();
      end
      #1;
      check("t1_inflight_full", inflight, 4);
      check("t1_alloc_ready_full", alloc_ready, 0);
      check("t1_ghr", ghr, 32'h000F);
      alloc_valid = 1'b0;

      // Test 2: all correct; each entry retires the cycle after its resolve.
      for (int i = 0; i < 4; i++) begin
         resolve(2'(i), 1'b1, 32'h900);
         #1;
         check("t2_res_ready", res_ready, 1);
         step();
         check("t2_flush", flush, 0);
         check("t2_train_valid", train_valid, 0);
         check("t2_inflight", inflight, (i == 0) ? 32'd4 : 32'(4 - i));
      end
      res_valid = 1'b0;
      #1;
      check("t2_res_ready_empty", res_ready, 0);
      step();
      check("t2_inflight_end", inflight, 0);
      check("t2_train_valid_end", train_valid, 0);

      // Test 3: mispredict on tag0 squashes tags 1,2 and refuses a same-cycle alloc.
      for (int i = 0; i < 3; i++) begin
         alloc(32'h200 + 32'(4 * i), 1'b1, 10'd100);
         step();
      end
      alloc_valid = 1'b0;
      check("t3_ghr_pre", ghr, 32'h007F);
      resolve(2'd0, 1'b0, 32'hDEAD);
      alloc(32'h600, 1'b1, 10'd100);
      #1;
      check("t3_alloc_refused", alloc_ready, 0);
      step();
      alloc_valid = 1'b0;
      res_valid   = 1'b0;
      #1;
      check("t3_flush", flush, 1);
      check("t3_flush_pc", flush_pc, 32'h204);
      check("t3_inflight", inflight, 1);
      check("t3_ghr_repair", ghr, 32'h001E);
      check("t3_res_ready", res_ready, 0);
      check("t3_train_valid", train_valid, 1);
      check("t3_train_pc", train_pc, 32'h200);
      check("t3_train_taken", train_taken, 0);
      check("t3_train_hist", train_hist, 32'h000F);
      step();
      check("t3_flush_pulse", flush, 0);
      check("t3_train_hold", train_valid, 1);
      train_ready = 1'b1;
      step();
      check("t3_inflight_end", inflight, 0);
      check("t3_train_done", train_valid, 0);
      train_ready = 1'b0;

      // Test 4: correct prediction with sum=-30 still trains; HLT and train_ready=0 hold it.
      alloc(32'h300, 1'b0, 10'h3E2);
      #1;
      check("t4_alloc_tag", alloc_tag, 1);
      step();
      alloc_valid = 1'b0;
      check("t4_ghr", ghr, 32'h003C);
      resolve(2'd1, 1'b0, 32'h0);
      #1;
      check("t4_alloc_ready_correct", alloc_ready, 1);
      step();
      res_valid = 1'b0;
      #1;
      check("t4_flush", flush, 0);
      check("t4_train_valid", train_valid, 1);
      check("t4_train_pc", train_pc, 32'h300);
      check("t4_train_taken", train_taken, 0);
      check("t4_train_hist", train_hist, 32'h001E);
      HLT = 1'b1;
      train_ready = 1'b1;
      #1;
      check("t4_hlt_alloc_ready", alloc_ready, 0);
      step();
      check("t4_hlt_train_valid", train_valid, 1);
      check("t4_hlt_inflight", inflight, 1);
      HLT = 1'b0;
      train_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         check("t4_hold_valid", train_valid, 1);
         check("t4_hold_pc", train_pc, 32'h300);
         check("t4_hold_inflight", inflight, 1);
      end
      train_ready = 1'b1;
      step();
      check("t4_retired", inflight, 0);
      check("t4_train_gone", train_valid, 0);
      train_ready = 1'b0;

      // Test 5: full queue, alloc vs retire in one cycle, wrap-around redirect PC.
      t5_pc[0] = 32'h400;      t5_sum[0] = 10'h200;
      t5_pc[1] = 32'h404;      t5_sum[1] = 10'h200;
      t5_pc[2] = 32'h408;      t5_sum[2] = 10'h200;
      t5_pc[3] = 32'hFFFFFFFC; t5_sum[3] = 10'd100;
      for (int i = 0; i < 4; i++) begin
         alloc(t5_pc[i], 1'b1, t5_sum[i]);
         #1;
         check("t5_alloc_tag", alloc_tag, 32'((2 + i) % 4));
         step();
      end
      alloc_valid = 1'b0;
      #1;
      check("t5_inflight_full", inflight, 4);
      check("t5_alloc_ready_full", alloc_ready, 0);
      resolve(2'd2, 1'b1, 32'h0);
      step();
      res_valid = 1'b0;
      alloc(32'h500, 1'b1, 10'd100);
      #1;
      check("t5_alloc_refused_on_retire", alloc_ready, 0);
      check("t5_no_train_min_sum", train_valid, 0);
      step();
      #1;
      check("t5_inflight_after_retire", inflight, 3);
      check("t5_alloc_ready_next", alloc_ready, 1);
      check("t5_alloc_tag_next", alloc_tag, 2);
      step();
      alloc_valid = 1'b0;
      check("t5_inflight_refill", inflight, 4);
      resolve(2'd3, 1'b1, 32'h0);
      step();
      check("t5_inflight_r3", inflight, 4);
      resolve(2'd0, 1'b1, 32'h0);
      step();
      check("t5_inflight_r0", inflight, 3);
      resolve(2'd1, 1'b0, 32'h0);
      step();
      res_valid = 1'b0;
      #1;
      check("t5_flush", flush, 1);
      check("t5_flush_pc_wrap", flush_pc, 32'h0);
      check("t5_inflight_misp_retire", inflight, 1);
      check("t5_ghr_repair", ghr, 32'h03CE);
      check("t5_res_ready_squashed", res_ready, 0);
      check("t5_train_valid", train_valid, 1);
      check("t5_train_pc", train_pc, 32'hFFFFFFFC);
      train_ready = 1'b1;
      step();
      check("t5_inflight_end", inflight, 0);
      check("t5_tag_err_clear", tag_err, 0);
      train_ready = 1'b0;

      // Test 6: reset mid-train, then an out-of-order tag raises tag_err.
      alloc(32'h700, 1'b1, 10'd10);
      step();
      alloc(32'h704, 1'b1, 10'd10);
      step();
      alloc_valid = 1'b0;
      resolve(2'd2, 1'b1, 32'h0);
      step();
      res_valid = 1'b0;
      #1;
      check("t6_train_valid_pre", train_valid, 1);
      check("t6_inflight_pre", inflight, 2);
      #2;
      RES = 1'b0;
      #1;
      check("t6_rst_train_valid", train_valid, 0);
      check("t6_rst_inflight", inflight, 0);
      check("t6_rst_ghr", ghr, 0);
      check("t6_rst_train_pc", train_pc, 0);
      check("t6_rst_train_hist", train_hist, 0);
      check("t6_rst_flush", flush, 0);
      check("t6_rst_flush_pc", flush_pc, 0);
      check("t6_rst_res_ready", res_ready, 0);
      step();
      RES = 1'b1;
      alloc(32'h800, 1'b1, 10'd100);
      #1;
      check("t6_first_tag", alloc_tag, 0);
      step();
      alloc_valid = 1'b0;
      resolve(2'd1, 1'b1, 32'h0);
      #1;
      check("t6_res_ready", res_ready, 1);
      check("t6_tag_err_pre", tag_err, 0);
      step();
      res_valid = 1'b0;
      #1;
      check("t6_tag_err_set", tag_err, 1);
      check("t6_no_flush", flush, 0);
      step();
      check("t6_tag_err_sticky", tag_err, 1);
      check("t6_inflight_end", inflight, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
